// File: rtl/q_mul_wb8.sv
// q_mul_wb8 -- write-back packer behind the 8-bit quantized multiply core.
//
// Collects the core's result bytes (INPUT_EN / C_IN) and packs four of them
// into each 32-bit word, little-endian. Words are written to the output SRAM
// starting at a programmed base address. A job covers a programmed number of
// elements. A partial last word is flushed with byte enables, and DONE pulses
// once the job is complete. A beat that arrives outside a job sets ERR_OVF.
//
// Ports
//   CLK        in   clock, rising edge
//   RESET_X    in   asynchronous active-low reset
//   START      in   one-cycle job start; ignored unless idle
//   LEN        in   element count, sampled on START (0 = empty job)
//   BASE_ADDR  in   first word address, sampled on START
//   INPUT_EN   in   result beat valid (no backpressure)
//   C_IN       in   result byte
//   WR_EN      out  registered SRAM word write strobe
//   WR_ADDR    out  write word address (holds when WR_EN=0)
//   WR_DATA    out  packed word, element n in byte lane n%4
//   WR_BE      out  byte enables, bit i covers WR_DATA[8i+7:8i]
//   BUSY       out  job in progress (RUN or LAST)
//   DONE       out  one-cycle pulse after the final word write
//   ERR_OVF    out  sticky out-of-job beat flag, cleared by an accepted START
//   dbg_state  out  current FSM state, for observation only
//
// Handshake: INPUT_EN is a valid-only stream. There is no ready; the block
// takes every beat in RUN. A beat in any other state is dropped and sets
// ERR_OVF. WR_EN is a one-cycle strobe with no acknowledge.
module q_mul_wb8 #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET_X,
  input  logic              START,
  input  logic [LEN_W-1:0]  LEN,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic              INPUT_EN,
  input  logic [7:0]        C_IN,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [31:0]       WR_DATA,
  output logic [3:0]        WR_BE,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR_OVF,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  k_q, k_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [31:0]       pack_q, pack_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [3:0]        wr_be_q, wr_be_d;
  logic              err_q, err_d;
  // Set for an empty job. FIN then waits one extra cycle, so DONE arrives two
  // cycles after START, the same spacing as from a last beat.
  logic              zlen_q, zlen_d;

  logic [1:0]        lane;
  logic              is_last;
  logic [31:0]       beat_word;
  logic [3:0]        last_be;

  assign lane    = k_q[1:0];
  assign is_last = (k_q == (len_q - LEN_W'(1)));

  // For the final word, enable lanes 0 up to the lane of the last element.
  always_comb begin
    last_be = 4'b0001;
    case (lane)
      2'd0: last_be = 4'b0001;
      2'd1: last_be = 4'b0011;
      2'd2: last_be = 4'b0111;
      2'd3: last_be = 4'b1111;
      default: last_be = 4'b0001;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    k_d       = k_q;
    ptr_d     = ptr_q;
    pack_d    = pack_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_be_d   = wr_be_q;
    err_d     = err_q;
    zlen_d    = zlen_q;
    beat_word = pack_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          err_d = 1'b0;
          if (LEN != '0) begin
            len_d   = LEN;
            ptr_d   = BASE_ADDR;
            k_d     = '0;
            pack_d  = '0;
            state_d = S_RUN;
          end else begin
            zlen_d  = 1'b1;
            state_d = S_FIN;
          end
        end
      end

      S_RUN: begin
        if (INPUT_EN) begin
          beat_word[{lane, 3'b000} +: 8] = C_IN;
          k_d = k_q + LEN_W'(1);
          if (lane == 2'd3 || is_last) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = beat_word;
            wr_be_d   = is_last ? last_be : 4'b1111;
            ptr_d     = ptr_q + ADDR_W'(1);
            // The pack register starts each word at zero. This keeps the
            // unused lanes of a partial final word at zero.
            pack_d    = '0;
          end else begin
            pack_d = beat_word;
          end
          if (is_last) state_d = S_LAST;
        end
      end

      S_LAST: state_d = S_FIN;

      S_FIN: begin
        if (zlen_q) zlen_d = 1'b0;
        else        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // An out-of-job beat wins over the clear from a START in the same cycle.
    if (INPUT_EN && state_q != S_RUN) err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      k_q       <= '0;
      ptr_q     <= '0;
      pack_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      err_q     <= 1'b0;
      zlen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      k_q       <= k_d;
      ptr_q     <= ptr_d;
      pack_q    <= pack_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
      err_q     <= err_d;
      zlen_q    <= zlen_d;
    end
  end

  assign WR_EN     = wr_en_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;
  assign WR_BE     = wr_be_q;
  assign ERR_OVF   = err_q;
  assign BUSY      = (state_q == S_RUN) || (state_q == S_LAST);
  assign DONE      = (state_q == S_FIN) && !zlen_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_q_mul_wb8.sv
// Testbench for q_mul_wb8. The stimulus task pushes the expected SRAM writes
// from a reference model into a queue. A monitor on the falling edge pops and
// compares each write, and also records DONE and BUSY activity.
module tb_q_mul_wb8;

  logic        CLK = 1'b0;
  logic        RESET_X = 1'b0;
  logic        START = 1'b0;
  logic [15:0] LEN = '0;
  logic [15:0] BASE_ADDR = '0;
  logic        INPUT_EN = 1'b0;
  logic [7:0]  C_IN = '0;
  logic        WR_EN;
  logic [15:0] WR_ADDR;
  logic [31:0] WR_DATA;
  logic [3:0]  WR_BE;
  logic        BUSY;
  logic        DONE;
  logic        ERR_OVF;
  logic [1:0]  dbg_state;

  q_mul_wb8 #(.ADDR_W(16), .LEN_W(16)) dut (
    .CLK(CLK), .RESET_X(RESET_X), .START(START), .LEN(LEN),
    .BASE_ADDR(BASE_ADDR), .INPUT_EN(INPUT_EN), .C_IN(C_IN),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_BE(WR_BE),
    .BUSY(BUSY), .DONE(DONE), .ERR_OVF(ERR_OVF), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [51:0] exp_q[$];   // {addr[15:0], be[3:0], data[31:0]}
  logic [7:0]  beats[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int busy_cnt = 0;
  logic [51:0] mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: element n goes to word n/4, lane n%4; word w sits at
  // base+w modulo 2^16, and lanes past the end of the job stay 0 and disabled.
  task automatic push_expected(input int len, input logic [15:0] base);
    for (int w = 0; w < (len + 3) / 4; w++) begin
      logic [31:0] word;
      logic [3:0]  be;
      logic [15:0] addr;
      word = '0;
      be   = '0;
      for (int l = 0; l < 4; l++) begin
        if (4 * w + l < len) begin
          word = word | (32'(beats[4 * w + l]) << (8 * l));
          be   = be | 4'(1 << l);
        end
      end
      addr = base + 16'(w);
      exp_q.push_back({addr, be, word});
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (RESET_X) begin
      if (BUSY) busy_cnt++;
      if (DONE) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (WR_EN) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {16'h0, WR_ADDR, WR_BE, WR_DATA}, 64'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 64'(WR_ADDR), 64'(mon_e[51:36]));
          check("wr_be",   64'(WR_BE),   64'(mon_e[35:32]));
          check("wr_data", 64'(WR_DATA), 64'(mon_e[31:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill_seq(input logic [7:0] first, input int n);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back(first + 8'(i));
  endtask

  task automatic fill_rand(input int n);
    beats.delete();
    for (int i = 0; i < n; i++) beats.push_back(8'($urandom_range(0, 255)));
  endtask

  // Runs one job, optionally with random gaps between beats and with a stray
  // START in the middle. It then checks DONE timing, that every write came
  // out, ERR_OVF and BUSY.
  task automatic run_job(input int len, input logic [15:0] base,
                         input bit gaps, input bit mid_start);
    int last_c;
    int done0;
    int busy0;
    int n;
    push_expected(len, base);
    done0 = done_cnt;
    busy0 = busy_cnt;
    START = 1'b1;
    LEN = 16'(len);
    BASE_ADDR = base;
    last_c = cyc;
    tick();
    START = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      INPUT_EN = 1'b1;
      C_IN = beats[i];
      if (mid_start && i == len / 2) begin
        START = 1'b1;
        LEN = 16'd3;
        BASE_ADDR = 16'h55AA;
      end
      last_c = cyc;
      tick();
      INPUT_EN = 1'b0;
      START = 1'b0;
    end
    n = 0;
    while (done_cnt == done0 && n < 100) begin
      tick();
      n++;
    end
    check("done_count", 64'(done_cnt - done0), 64'd1);
    check("done_cycle", 64'(done_cyc), 64'(last_c + 2));
    check("writes_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check("err_ovf_job", 64'(ERR_OVF), 64'd0);
    check("busy_seen", 64'(busy_cnt != busy0), 64'(len != 0));
    check("done_pulse_low", 64'(DONE), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    RESET_X = 1'b0;
    repeat (3) tick();
    check("rst_wr_en",   64'(WR_EN),   64'd0);
    check("rst_wr_addr", 64'(WR_ADDR), 64'd0);
    check("rst_wr_data", 64'(WR_DATA), 64'd0);
    check("rst_wr_be",   64'(WR_BE),   64'd0);
    check("rst_busy",    64'(BUSY),    64'd0);
    check("rst_done",    64'(DONE),    64'd0);
    check("rst_err",     64'(ERR_OVF), 64'd0);
    RESET_X = 1'b1;
    tick();

    // Two full words, back-to-back beats.
    fill_seq(8'h01, 8);
    run_job(8, 16'h0010, 1'b0, 1'b0);

    // Partial final word, random gaps.
    fill_seq(8'hA0, 6);
    run_job(6, 16'h0020, 1'b1, 1'b0);

    // Empty job.
    beats.delete();
    run_job(0, 16'h0030, 1'b0, 1'b0);

    // Address wrap at the top of the address space.
    fill_rand(8);
    run_job(8, 16'hFFFF, 1'b0, 1'b0);

    // Beat while idle: dropped, sets ERR_OVF; the next START clears it, and a
    // START during RUN does not disturb the job.
    INPUT_EN = 1'b1;
    C_IN = 8'h77;
    tick();
    INPUT_EN = 1'b0;
    tick();
    check("err_idle_beat", 64'(ERR_OVF), 64'd1);
    fill_seq(8'h40, 8);
    run_job(8, 16'h0100, 1'b1, 1'b1);

    // A beat in the same cycle as an accepted START sets ERR_OVF.
    START = 1'b1;
    LEN = 16'd0;
    INPUT_EN = 1'b1;
    tick();
    START = 1'b0;
    INPUT_EN = 1'b0;
    repeat (3) tick();
    check("err_start_beat", 64'(ERR_OVF), 64'd1);

    // Reset in the middle of a job.
    fill_seq(8'h11, 3);
    START = 1'b1;
    LEN = 16'd8;
    BASE_ADDR = 16'h0040;
    tick();
    START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      INPUT_EN = 1'b1;
      C_IN = beats[i];
      tick();
    end
    INPUT_EN = 1'b0;
    d0 = done_cnt;
    RESET_X = 1'b0;
    #1;
    check("midrst_wr_en", 64'(WR_EN),   64'd0);
    check("midrst_busy",  64'(BUSY),    64'd0);
    check("midrst_done",  64'(DONE),    64'd0);
    check("midrst_data",  64'(WR_DATA), 64'd0);
    check("midrst_be",    64'(WR_BE),   64'd0);
    check("midrst_err",   64'(ERR_OVF), 64'd0);
    repeat (3) tick();
    RESET_X = 1'b1;
    repeat (4) tick();
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);

    // Fresh job after the reset.
    fill_seq(8'hC0, 5);
    run_job(5, 16'h0200, 1'b0, 1'b0);

    // Random jobs.
    for (int j = 0; j < 8; j++) begin
      int len;
      len = $urandom_range(1, 23);
      fill_rand(len);
      run_job(len, 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/q_mul_wb8.md
# q_mul_wb8

Write-back packer directly downstream of the 8-bit quantized multiply core: captures its OUTPUT_EN/C_OUT result stream, packs four 8-bit results per 32-bit word (little-endian) and issues word writes to the output SRAM starting at a programmed base address. It counts a programmed number of elements per job, flushes a partial final word with byte enables, pulses DONE, and flags any result beat that arrives outside a job.

## Interface
- ADDR_W, 16, width of the SRAM word address; addresses wrap modulo 2^ADDR_W.
- LEN_W, 16, width of the element-count register.
- CLK  in  1  single clock; all logic on the rising edge.
- RESET_X  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle job start pulse; ignored while BUSY=1.
- LEN  in  LEN_W  number of 8-bit elements in the job; sampled on START.
- BASE_ADDR  in  ADDR_W  first word address; sampled on START.
- INPUT_EN  in  1  result beat valid (from the multiply core OUTPUT_EN); no backpressure.
- C_IN  in  8  result byte (from the multiply core C_OUT).
- WR_EN  out  1  SRAM word write strobe, registered.
- WR_ADDR  out  ADDR_W  write word address, registered.
- WR_DATA  out  32  packed word; element n at bits [8*(n%4)+7 : 8*(n%4)].
- WR_BE  out  4  byte enables; bit i covers WR_DATA[8i+7:8i].
- BUSY  out  1  job in progress.
- DONE  out  1  one-cycle pulse after the final word write.
- ERR_OVF  out  1  sticky: a beat arrived while not in RUN; cleared by an accepted START.

## Operation
- States: IDLE, RUN, LAST, FIN. Reset -> IDLE; all outputs 0, counters and pack register 0.
- IDLE: START with LEN!=0 -> latch LEN, BASE_ADDR; element counter k=0; word pointer=BASE_ADDR; clear ERR_OVF; -> RUN. START with LEN=0 -> clear ERR_OVF, -> FIN (no writes).
- RUN: each INPUT_EN beat stores C_IN in lane k%4 and increments k. If k%4==3 and the beat is not the last, next cycle WR_EN=1, WR_BE=4'b1111, WR_ADDR=pointer, then pointer+1; pack register cleared. If the beat is the last (k==LEN-1) -> LAST.
- LAST: WR_EN=1 with the final word; WR_BE has lanes 0..(LEN-1)%4 set; unused lanes of WR_DATA are 0. -> FIN.
- FIN: DONE=1 for one cycle; -> IDLE.
- BUSY=1 in RUN and LAST; 0 in IDLE and FIN.
- START while BUSY or in FIN: ignored, no effect on latched job.
- INPUT_EN in IDLE, LAST or FIN: beat dropped, ERR_OVF<=1. A beat in the same cycle as an accepted START is dropped and sets ERR_OVF (set wins over the START clear).
- Pointer increments modulo 2^ADDR_W (BASE_ADDR near the top wraps to 0). LEN counts full range up to 2^LEN_W-1.
- Reset asserted mid-job: immediate return to IDLE, outputs 0, partial word discarded, no DONE.

## Timing
- Beat completing a word (or last beat) at cycle t -> WR_EN at t+1; for the last beat DONE at t+2.
- WR_EN high for exactly one cycle per word; back-to-back beats give one write every 4 cycles, no stalls, no dropped beats in RUN.
- Total writes per job = ceil(LEN/4). LEN=0: START at t -> DONE at t+2, no WR_EN.
- Earliest next START accepted in the cycle DONE is high's following cycle (IDLE).
- WR_ADDR, WR_DATA, WR_BE hold their last value when WR_EN=0 (don't-care to SRAM).

## Test plan
- LEN=8, BASE=0x0010, beats 0x01..0x08 back-to-back -> writes 0x04030201@0x0010, 0x08070605@0x0011, BE=1111; DONE one cycle after second write; ERR_OVF=0.
- LEN=6, BASE=0x0020, beats 0xA0..0xA5 with random gaps -> 0xA3A2A1A0@0x0020 BE=1111, 0x0000A5A4@0x0021 BE=0011; DONE at last beat +2.
- LEN=0 START -> no WR_EN, DONE pulse 2 cycles later, BUSY never 1.
- LEN=8, BASE=0xFFFF -> writes at 0xFFFF then 0x0000.
- Beat while IDLE -> no write, ERR_OVF=1; next START clears it; START during RUN ignored (job completes with original LEN/BASE).
- RESET_X low after 3 beats of LEN=8 -> all outputs 0 immediately, no write, no DONE; fresh job afterward completes correctly.
